// File: rtl/mux_two_arbiter_if.sv
// Request/grant bundle between the two requesters and the 2:1 mux arbiter.
interface mux_two_arbiter_if #(parameter int CNT_W = 8);
  logic             req_a;
  logic             req_b;
  logic             sel;
  logic             gnt_a;
  logic             gnt_b;
  logic             busy;
  logic             preempt;
  logic [CNT_W-1:0] hold_cnt;

  modport master (output req_a, req_b,
                  input  sel, gnt_a, gnt_b, busy, preempt, hold_cnt);
  modport slave  (input  req_a, req_b,
                  output sel, gnt_a, gnt_b, busy, preempt, hold_cnt);
endinterface

// File: rtl/mux_two_arbiter.sv
// Two-requester round-robin arbiter with hold-time preemption driving a 2:1 mux select.
// Define MUX_TWO_ARB_GAP_EN to insert one idle GAP cycle on every owner change.
module mux_two_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  mux_two_arbiter_if.slave  bus
);

`ifdef MUX_TWO_ARB_GAP_EN
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
`endif

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic             gnt_a_q, gnt_b_q;
  logic             pre_q, pre_d;
  logic             last_q, last_d;   // 1 = B owned last
  logic [CNT_W-1:0] hold_q, hold_d;

  logic go, go_b;      // enter a grant this edge, and to which side
  logic hand, hand_b;  // owner change requested, and to which side
  logic own_req, oth_req;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    last_d  = last_q;
    pre_d   = 1'b0;
    go      = 1'b0;
    go_b    = 1'b0;
    hand    = 1'b0;
    hand_b  = 1'b0;
    own_req = (state_q == OWN_B) ? bus.req_b : bus.req_a;
    oth_req = (state_q == OWN_B) ? bus.req_a : bus.req_b;

    case (state_q)
      IDLE: begin
        hold_d = '0;
        if (bus.req_a && (!bus.req_b || last_q)) begin
          go = 1'b1;
        end else if (bus.req_b) begin
          go   = 1'b1;
          go_b = 1'b1;
        end
      end
      OWN_A, OWN_B: begin
        if (!own_req) begin
          if (oth_req) begin
            hand   = 1'b1;
            hand_b = (state_q == OWN_A);
          end else begin
            state_d = IDLE;
            hold_d  = '0;
          end
        end else if (hold_q == HOLD_LAST) begin
          if (oth_req) begin
            hand   = 1'b1;
            hand_b = (state_q == OWN_A);
            pre_d  = 1'b1;
          end else begin
            hold_d = '0;
          end
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
`ifdef MUX_TWO_ARB_GAP_EN
      GAP: begin
        // sel already points at the pending owner; fall back to the old one if it left
        if (sel_q ? bus.req_b : bus.req_a) begin
          go   = 1'b1;
          go_b = sel_q;
        end else if (sel_q ? bus.req_a : bus.req_b) begin
          go   = 1'b1;
          go_b = !sel_q;
        end else begin
          state_d = IDLE;
          hold_d  = '0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase

`ifdef MUX_TWO_ARB_GAP_EN
    if (hand) begin
      state_d = GAP;
      sel_d   = hand_b;
      hold_d  = '0;
    end
`else
    if (hand) begin
      go   = 1'b1;
      go_b = hand_b;
    end
`endif

    if (go) begin
      state_d = go_b ? OWN_B : OWN_A;
      sel_d   = go_b;
      hold_d  = '0;
      last_d  = go_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      pre_q   <= 1'b0;
      last_q  <= 1'b1;
      hold_q  <= '0;
    end else if (ena) begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_a_q <= (state_d == OWN_A);
      gnt_b_q <= (state_d == OWN_B);
      pre_q   <= pre_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.sel      = sel_q;
  assign bus.gnt_a    = gnt_a_q;
  assign bus.gnt_b    = gnt_b_q;
  assign bus.busy     = gnt_a_q | gnt_b_q;
  assign bus.preempt  = pre_q;
  assign bus.hold_cnt = hold_q;

endmodule

// File: doc/mux_two_arbiter.md
Name: mux_two_arbiter

Overview:
- Two-requester round-robin arbiter that sequences the shared 2:1 mux.
- Drives the mux select line (sel: 0 = input a, 1 = input b) and issues registered one-hot grants.
- Enforces a maximum hold time per grant, so neither requester can starve the other.
- Sits beside the mux inside the tt_um top; requests come from ui_in bits, grants/status go to uo_out.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles while the other side is requesting; legal range 2..255.
- CNT_W, 8, hold-counter width; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- ena  input  1  clock enable; low freezes all state and outputs
- req_a  input  1  requester A wants the mux (level)
- req_b  input  1  requester B wants the mux (level)
- sel  output  1  mux select; 0 = a, 1 = b (registered)
- gnt_a  output  1  A owns the mux (registered)
- gnt_b  output  1  B owns the mux (registered)
- busy  output  1  gnt_a | gnt_b
- preempt  output  1  one-cycle pulse when a grant is revoked by hold expiry
- hold_cnt  output  CNT_W  cycles elapsed in the current grant (debug)

Behaviour:
- Reset values (rst high at a clock edge): state=IDLE, sel=0, gnt_a=0, gnt_b=0, preempt=0, hold_cnt=0, last_owner=B (so A wins the first tie). rst overrides ena.
- ena=0: no state, counter or output changes; preempt holds its last value.
- All decisions use req_* sampled at edge N; the resulting grants/sel appear after edge N. Latency from request to grant is 1 cycle.
- gnt_a and gnt_b are never both 1. sel changes only on the same edge that grants the new owner.
- IDLE:
  - req_a & req_b → grant the side that is not last_owner.
  - Only one req → grant that side.
  - No req → stay IDLE; sel keeps its last value; hold_cnt=0.
- OWN_A (OWN_B symmetric):
  - req_a=0 → release. Go to OWN_B if req_b=1, else IDLE.
  - req_a=1, req_b=1, hold_cnt==MAX_HOLD-1 → preempt. Go to OWN_B and pulse preempt=1 for 1 cycle.
  - req_a=1, req_b=0 at expiry → keep the grant, clear hold_cnt to 0, no preempt.
  - Otherwise hold_cnt increments by 1.
- hold_cnt:
  - Cleared to 0 on every grant entry.
  - Counts 0..MAX_HOLD-1 while the other side is requesting.
  - When the other side is not requesting, wraps to 0 after MAX_HOLD-1.
  - Never exceeds MAX_HOLD-1.
- last_owner updates on every grant entry.
- Direct handoff A→B (or B→A) takes 0 idle cycles when the gap feature is off.
- Requests dropped and reasserted in the same cycle are ignored: the level sampled at the edge governs.
- Reset mid-grant ends the grant on the next edge. There are no other side effects.

Optional Feature:
- Macro: MUX_TWO_ARB_GAP_EN.
- Defined:
  - Every owner change (A→B, B→A, including preempt) passes through a GAP state for exactly 1 cycle, with gnt_a=gnt_b=0 and busy=0.
  - sel switches on entry to GAP.
  - The new grant asserts on the following edge. Handoff latency is 2 cycles.
  - Requests are re-evaluated at the exit from GAP. If the pending requester has dropped, go to IDLE, or back to the previous owner if it is still requesting.
  - preempt pulses on entry to GAP.
- Undefined: no GAP state; behaviour is exactly as above.

Test Plan:
- Reset: assert rst 2 cycles with req_a=req_b=1 → all outputs 0. After release, gnt_a=1 and sel=0 one cycle later (tie goes to A).
- Single requester: req_b=1 only, 20 cycles → gnt_b=1 and sel=1 throughout, preempt never pulses, hold_cnt wraps 7→0 at MAX_HOLD=8.
- Contention: req_a=req_b=1 held for 40 cycles, MAX_HOLD=8 → grants alternate every 8 cycles starting with A, preempt pulses 4 times, gnt_a and gnt_b never both 1.
- Early release: A granted, req_a drops at hold_cnt=3 with req_b=1 → gnt_b=1, sel=1 on the next edge, no preempt.
- ena freeze: deassert ena mid-grant at hold_cnt=5 for 4 cycles while toggling requests → all outputs constant. Counting resumes from 5 when ena returns.
- Gap feature (MUX_TWO_ARB_GAP_EN): contention as above → one busy=0 cycle between owners, with sel already at the new value during that cycle.
